m_store_buffer: RTL and testbench

- Parametrised successor to the MEM-stage byte-enable generator.
- Accepts store requests from the MEM stage and checks alignment.
- Generates lane-shifted write data and byte enables for a DW-bit memory word.
- Queues accepted stores in a DEPTH-entry FIFO that drains to the data-memory bus over a valid/ready handshake, so the pipeline need not stall on a slow memory.

---
 rtl/m_store_buffer_pkg.sv | 23 ++
 rtl/m_store_align.sv | 48 ++++
 rtl/m_store_buffer.sv | 137 +++++++++++++
 tb/tb_m_store_buffer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_store_buffer_pkg.sv
// Shared store-op opcodes and lane-mask helper for the MEM-stage store buffer.
// Extends the existing DM_* opcode set with the doubleword store.
package m_store_buffer_pkg;

  localparam logic [2:0] DM_w = 3'd0;
  localparam logic [2:0] DM_h = 3'd1;
  localparam logic [2:0] DM_b = 3'd2;
  localparam logic [2:0] DM_d = 3'd3;

  function automatic logic [7:0] base_mask(input logic [2:0] op);
    logic [7:0] m;
    m = 8'h00;
    unique case (1'b1)
      op == DM_b: m = 8'h01;
      op == DM_h: m = 8'h03;
      op == DM_w: m = 8'h0F;
      op == DM_d: m = 8'hFF;
      default:    m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/m_store_align.sv
// Store lane alignment: byte offset, data and op -> byte enables,
// lane-placed write data and the AdES illegal flag.
module m_store_align
  import m_store_buffer_pkg::*;
#(
  parameter  int DW = 32,
  localparam int NB = DW / 8,
  localparam int LB = $clog2(NB)
) (
  input  logic [LB-1:0] off,
  input  logic [DW-1:0] data,
  input  logic [2:0]    op,
  output logic [NB-1:0] byteen,
  output logic [DW-1:0] wdata,
  output logic          illegal
);

  logic [7:0]    mask_full;
  logic [NB-1:0] mask;
  logic [DW-1:0] dmask;
  logic [DW-1:0] data_m;

  always_comb begin
    illegal = 1'b1;
    unique case (1'b1)
      op == DM_b: illegal = 1'b0;
      op == DM_h: illegal = off[0];
      op == DM_w: illegal = |off[1:0];
      op == DM_d: illegal = (DW != 64) || (|off);
      default:    illegal = 1'b1;
    endcase
  end

  always_comb begin
    mask_full = base_mask(op);
    mask      = mask_full[NB-1:0];
    dmask     = '0;
    for (int i = 0; i < NB; i++) begin
      dmask[8*i +: 8] = {8{mask[i]}};
    end
    data_m = data & dmask;
  end

  // Illegal stores never enqueue, so zero their lanes outright.
  assign byteen = illegal ? '0 : NB'(mask << off);
  assign wdata  = illegal ? '0 : DW'(data_m << {off, 3'b000});

endmodule

// File: rtl/m_store_buffer.sv
// MEM-stage store buffer: align, queue and drain stores over valid/ready.
// Optional STORE_MERGE_EN merges same-word stores into the youngest entry.
module m_store_buffer
  import m_store_buffer_pkg::*;
#(
  parameter  int DW    = 32,
  parameter  int DEPTH = 4,
  parameter  int AW    = 32,
  localparam int NB    = DW / 8,
  localparam int LB    = $clog2(NB),
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  input  logic [2:0]    st_op,
  output logic          st_exc,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic [NB-1:0] mem_byteen,
  output logic [DW-1:0] mem_wdata,
  output logic [CW-1:0] count
);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [NB-1:0] be_q   [DEPTH];
  logic [NB-1:0] be_d   [DEPTH];
  logic [DW-1:0] wd_q   [DEPTH];
  logic [DW-1:0] wd_d   [DEPTH];

  logic [NB-1:0] al_be;
  logic [DW-1:0] al_wd;
  logic          al_ill;
  logic [AW-1:0] waddr;
  logic          full;
  logic          empty;
  logic          accept;
  logic          do_push;
  logic          pop;

  m_store_align #(.DW(DW)) u_align (
    .off     (st_addr[LB-1:0]),
    .data    (st_data),
    .op      (st_op),
    .byteen  (al_be),
    .wdata   (al_wd),
    .illegal (al_ill)
  );

  assign waddr  = {st_addr[AW-1:LB], {LB{1'b0}}};
  assign full   = cnt_q == CW'(DEPTH);
  assign empty  = cnt_q == '0;
  assign st_exc = st_valid & al_ill;
  assign accept = st_valid & st_ready & ~al_ill;
  assign pop    = mem_valid & mem_ready;

`ifdef STORE_MERGE_EN
  logic [PW-1:0] young;
  logic          merge_hit;
  logic          do_merge;

  // The head is presented on the bus, so only a non-head youngest merges.
  assign young     = tail_q - PW'(1);
  assign merge_hit = st_valid & ~al_ill & (cnt_q >= CW'(2))
                   & (addr_q[young] == waddr);
  assign st_ready  = ~full | merge_hit;
  assign do_merge  = accept & merge_hit;
  assign do_push   = accept & ~merge_hit;
`else
  assign st_ready  = ~full;
  assign do_push   = accept;
`endif

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    addr_d = addr_q;
    be_d   = be_q;
    wd_d   = wd_q;
    if (do_push) begin
      addr_d[tail_q] = waddr;
      be_d[tail_q]   = al_be;
      wd_d[tail_q]   = al_wd;
      tail_d         = tail_q + PW'(1);
    end
`ifdef STORE_MERGE_EN
    if (do_merge) begin
      be_d[young] = be_q[young] | al_be;
      for (int i = 0; i < NB; i++) begin
        if (al_be[i]) wd_d[young][8*i +: 8] = al_wd[8*i +: 8];
      end
    end
`endif
    if (pop) head_d = head_q + PW'(1);
    unique case ({do_push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    be_q   <= be_d;
    wd_q   <= wd_d;
  end

  assign mem_valid  = ~empty;
  assign mem_addr   = empty ? '0 : addr_q[head_q];
  assign mem_byteen = empty ? '0 : be_q[head_q];
  assign mem_wdata  = empty ? '0 : wd_q[head_q];
  assign count      = cnt_q;

endmodule

// File: tb/tb_m_store_buffer.sv
// Directed bench for m_store_buffer with a queue scoreboard.
// Checks both the default and STORE_MERGE_EN builds.
module tb_m_store_buffer;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_op;
  logic        st_exc;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata;
  logic [2:0]  count;

  logic        v64;
  logic        rdy64;
  logic [31:0] a64;
  logic [63:0] d64;
  logic [2:0]  op64;
  logic        exc64;
  logic        mv64;
  logic [31:0] ma64;
  logic [7:0]  mbe64;
  logic [63:0] mwd64;
  logic [2:0]  cnt64;

  int nerr = 0;
  int nchk = 0;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
  } ent_t;

  ent_t sbq[$];

  m_store_buffer #(.DW(32), .DEPTH(4), .AW(32)) u_dut (
    .clk        (clk),
    .reset      (rst),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_op      (st_op),
    .st_exc     (st_exc),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_byteen (mem_byteen),
    .mem_wdata  (mem_wdata),
    .count      (count)
  );

  m_store_buffer #(.DW(64), .DEPTH(4), .AW(32)) u_dut64 (
    .clk        (clk),
    .reset      (rst),
    .st_valid   (v64),
    .st_ready   (rdy64),
    .st_addr    (a64),
    .st_data    (d64),
    .st_op      (op64),
    .st_exc     (exc64),
    .mem_valid  (mv64),
    .mem_ready  (1'b1),
    .mem_addr   (ma64),
    .mem_byteen (mbe64),
    .mem_wdata  (mwd64),
    .count      (cnt64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic fail(input string t);
    nerr++;
    $error("FAIL %s", t);
  endtask

  function automatic void mdl(input logic [31:0] a, input logic [31:0] d,
                              input logic [2:0] op, output logic [3:0] be,
                              output logic [31:0] wd, output logic ill);
    int off;
    off = int'(a[1:0]);
    be  = 4'h0;
    wd  = 32'h0;
    ill = 1'b1;
    case (op)
      3'd2: begin ill = 1'b0; be = 4'b0001 << off; wd = (d & 32'hFF) << (8*off); end
      3'd1: begin ill = a[0]; be = 4'b0011 << off; wd = (d & 32'hFFFF) << (8*off); end
      3'd0: begin ill = (off != 0); be = 4'hF; wd = d; end
      default: ;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] op);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_op    = op;
  endtask

  task automatic tick();
    ent_t        e;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        ill;
    logic        hit;
    logic        rdy;
    logic [31:0] wa;
    #1;
    if (rst) begin
      sbq.delete();
    end else begin
      mdl(st_addr, st_data, st_op, be, wd, ill);
      wa  = {st_addr[31:2], 2'b00};
      hit = 1'b0;
`ifdef STORE_MERGE_EN
      if (st_valid && !ill && sbq.size() >= 2) hit = (sbq[$].a == wa);
`endif
      rdy = (sbq.size() < 4) || hit;
      nchk++; if (st_ready !== rdy) fail("st_ready");
      nchk++; if (st_exc !== (st_valid & ill)) fail("st_exc");
      nchk++; if (mem_valid !== (sbq.size() != 0)) fail("mem_valid");
      if (sbq.size() != 0 && mem_ready) begin
        e = sbq.pop_front();
        nchk++; if (mem_addr !== e.a) fail("mem_addr");
        nchk++; if (mem_byteen !== e.be) fail("mem_byteen");
        nchk++; if (mem_wdata !== e.wd) fail("mem_wdata");
      end
      if (st_valid && rdy && !ill) begin
        if (hit) begin
          sbq[sbq.size()-1].be = sbq[$].be | be;
          for (int i = 0; i < 4; i++)
            if (be[i]) sbq[sbq.size()-1].wd[8*i +: 8] = wd[8*i +: 8];
        end else begin
          e.a  = wa;
          e.be = be;
          e.wd = wd;
          sbq.push_back(e);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    nchk++; if (count !== 3'(sbq.size())) fail("count");
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 3'd0);
    v64 = 1'b0; a64 = 32'h0; d64 = 64'h0; op64 = 3'd0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    nchk++; if (mem_valid !== 1'b0) fail("rst_mem_valid");
    nchk++; if (mem_addr !== 32'h0) fail("rst_mem_addr");
    nchk++; if (mem_byteen !== 4'h0) fail("rst_mem_byteen");
    nchk++; if (mem_wdata !== 32'h0) fail("rst_mem_wdata");

    mem_ready = 1'b1;
    drive(1'b1, 32'h1003, 32'h0000_00AB, 3'd2);
    tick();
    drive(1'b0, 32'h0, 32'h0, 3'd0);
    nchk++; if (mem_addr !== 32'h1000) fail("sb_addr");
    nchk++; if (mem_byteen !== 4'b1000) fail("sb_byteen");
    nchk++; if (mem_wdata !== 32'hAB00_0000) fail("sb_wdata");
    tick();
    nchk++; if (count !== 3'd0) fail("sb_count0");

    drive(1'b1, 32'h2001, 32'h1234, 3'd1);
    tick();
    drive(1'b1, 32'h2002, 32'h1234, 3'd0);
    tick();
    drive(1'b1, 32'h2000, 32'h1234, 3'd3);
    tick();
    drive(1'b1, 32'h2000, 32'h1234, 3'd7);
    tick();
    drive(1'b0, 32'h0, 32'h0, 3'd0);

    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h3000 + 32'(4*i), 32'hA000_0000 + 32'(i), 3'd0);
      tick();
    end
    nchk++; if (st_ready !== 1'b0) fail("full_ready");
    drive(1'b0, 32'h0, 32'h0, 3'd0);
    mem_ready = 1'b1;
    repeat (4) tick();

    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h4000 + 32'(4*i), 32'hB000_0000 + 32'(i), 3'd0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 3'd0);
    tick();

    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h5000 + 32'(4*i), 32'hC000_0000 + 32'(i), 3'd0);
      tick();
    end
    drive(1'b1, 32'h5010, 32'hC000_0004, 3'd0);
    mem_ready = 1'b1;
    tick();
    nchk++; if (count !== 3'd3) fail("pp_count3");
    drive(1'b0, 32'h0, 32'h0, 3'd0);
    mem_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nchk++; if (mem_valid !== 1'b0) fail("rst_mid_valid");
    nchk++; if (count !== 3'd0) fail("rst_mid_count");

    drive(1'b1, 32'h0100, 32'hDEAD_BEEF, 3'd0);
    tick();
    drive(1'b1, 32'h0204, 32'h11, 3'd2);
    tick();
    drive(1'b1, 32'h0205, 32'h22, 3'd2);
    tick();
    drive(1'b0, 32'h0, 32'h0, 3'd0);
`ifdef STORE_MERGE_EN
    nchk++; if (count !== 3'd2) fail("merge_count");
`else
    nchk++; if (count !== 3'd3) fail("merge_count");
`endif
    mem_ready = 1'b1;
    tick();
`ifdef STORE_MERGE_EN
    nchk++; if (mem_byteen !== 4'b0011) fail("merge_byteen");
    nchk++; if (mem_wdata !== 32'h0000_2211) fail("merge_wdata");
`else
    nchk++; if (mem_byteen !== 4'b0001) fail("merge_byteen");
    nchk++; if (mem_wdata !== 32'h0000_0011) fail("merge_wdata");
`endif
    repeat (3) tick();

    v64 = 1'b1; a64 = 32'h6; d64 = 64'h1234; op64 = 3'd1;
    #1;
    nchk++; if (exc64 !== 1'b0) fail("d64_sh_exc");
    @(posedge clk);
    @(negedge clk);
    nchk++; if (mv64 !== 1'b1) fail("d64_sh_valid");
    nchk++; if (ma64 !== 32'h0) fail("d64_sh_addr");
    nchk++; if (mbe64 !== 8'b1100_0000) fail("d64_sh_byteen");
    nchk++; if (mwd64 !== 64'h1234_0000_0000_0000) fail("d64_sh_wdata");
    a64 = 32'h8; d64 = 64'h0102_0304_0506_0708; op64 = 3'd3;
    #1;
    nchk++; if (exc64 !== 1'b0) fail("d64_sd_exc");
    @(posedge clk);
    @(negedge clk);
    nchk++; if (ma64 !== 32'h8) fail("d64_sd_addr");
    nchk++; if (mbe64 !== 8'hFF) fail("d64_sd_byteen");
    nchk++; if (mwd64 !== 64'h0102_0304_0506_0708) fail("d64_sd_wdata");
    nchk++; if (cnt64 !== 3'd1) fail("d64_sd_count");
    a64 = 32'h4; op64 = 3'd3;
    #1;
    nchk++; if (exc64 !== 1'b1) fail("d64_sd_mis_exc");
    v64 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    nchk++; if (cnt64 !== 3'd0) fail("d64_count0");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
